// File: rtl/mult_csa_pkg.sv
// Shared helpers for the pipelined carry-save array multiplier.
//   num_stages() : compute-stage count, ceil(width / rows)
//   latency()    : accept-to-out_valid latency, num_stages() + 1
//   last_row()   : index of the final CSA row evaluated in a given stage
//   row_ctrl()   : Baugh-Wooley controls for one row (signed build only)
// Optional feature macro: MULT_CSA_SIGNED_EN (two's complement operands).
package mult_csa_pkg;

  typedef struct packed {
    logic inv_msb;  // invert a[W-1]&b[j]
    logic inv_low;  // invert a[W-2:0]&b[j]
    logic inject;   // constant 1 into the free top sum slot
  } row_ctrl_t;

  function automatic int unsigned num_stages(int unsigned width, int unsigned rows);
    return (width + rows - 1) / rows;
  endfunction

  function automatic int unsigned latency(int unsigned width, int unsigned rows);
    return num_stages(width, rows) + 1;
  endfunction

  function automatic int unsigned last_row(int unsigned stage, int unsigned width,
                                           int unsigned rows);
    return ((stage + 1) * rows > width) ? width - 1 : (stage + 1) * rows - 1;
  endfunction

  // Row j's free top sum slot carries weight 2^(j+W): row 0 lands the
  // column-W constant, row W-1 lands the column-(2W-1) constant.
  function automatic row_ctrl_t row_ctrl(int unsigned row, int unsigned width);
    row_ctrl_t c;
    c.inv_msb = (row != width - 1);
    c.inv_low = (row == width - 1);
    c.inject  = (row == 0) || (row == width - 1);
    return c;
  endfunction

endpackage

// File: rtl/mult_core.sv
// Full-adder cell used as the carry-save reduction element.
//   a_i, b_i, c_i : addends
//   s_o           : sum bit
//   co_o          : carry bit (weight 2)
module mult_core (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/mult_csa_row.sv
// One combinational carry-save row: adds partial product a & b_j into the
// incoming sum/carry vectors, retires the lowest bit as a product bit and
// returns the sum vector realigned by one position for the next row.
//   sum_i, carry_i : incoming carry-save vectors
//   a_i            : multiplicand
//   b_j_i          : multiplier bit for this row
//   ctrl_i         : Baugh-Wooley row controls (MULT_CSA_SIGNED_EN only)
//   sum_o, carry_o : outgoing carry-save vectors
//   p_o            : retired product bit
module mult_csa_row
  import mult_csa_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] sum_i,
  input  logic [Width-1:0] carry_i,
  input  logic [Width-1:0] a_i,
  input  logic             b_j_i,
`ifdef MULT_CSA_SIGNED_EN
  input  row_ctrl_t        ctrl_i,
`endif
  output logic [Width-1:0] sum_o,
  output logic [Width-1:0] carry_o,
  output logic             p_o
);

  logic [Width-1:0] pp;
  logic [Width-1:0] fa_s;
  logic [Width-1:0] fa_c;

  always_comb begin
    pp = a_i & {Width{b_j_i}};
`ifdef MULT_CSA_SIGNED_EN
    pp[Width-1]   = pp[Width-1] ^ ctrl_i.inv_msb;
    pp[Width-2:0] = pp[Width-2:0] ^ {(Width-1){ctrl_i.inv_low}};
`endif
  end

  for (genvar i = 0; i < Width; i++) begin : g_fa
    mult_core u_fa (
      .a_i (pp[i]),
      .b_i (sum_i[i]),
      .c_i (carry_i[i]),
      .s_o (fa_s[i]),
      .co_o(fa_c[i])
    );
  end

  assign p_o     = fa_s[0];
  assign carry_o = fa_c;
`ifdef MULT_CSA_SIGNED_EN
  assign sum_o   = {ctrl_i.inject, fa_s[Width-1:1]};
`else
  assign sum_o   = {1'b0, fa_s[Width-1:1]};
`endif

endmodule

// File: rtl/mult_csa_pipe.sv
// Pipelined WIDTH x WIDTH carry-save array multiplier with valid/ready
// handshakes. An input register bank is followed by NS compute stages of
// ROWS_PER_STAGE CSA rows each and a registered ripple merge; latency is NS+1.
// The whole pipe advances together when the output slot is free or drained.
//   clk_i, rst_n_i            : clock, async active-low reset
//   in_valid_i / in_ready_o   : operand handshake
//   a_i, b_i                  : operands
//   out_valid_o / out_ready_i : product handshake
//   p_o                       : 2*WIDTH-bit product
// Optional feature macro: MULT_CSA_SIGNED_EN (Baugh-Wooley signed multiply).
module mult_csa_pipe
  import mult_csa_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned ROWS_PER_STAGE = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] p_o
);

  localparam int unsigned NS = num_stages(WIDTH, ROWS_PER_STAGE);
  localparam int unsigned R  = ROWS_PER_STAGE;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] plo;  // product bits already retired by earlier rows
  } stage_t;

  // pipe_q[0] is the operand capture bank; pipe_q[k+1] follows compute stage k.
  stage_t pipe_q [NS+1];
  stage_t pipe_d [NS+1];

  logic               out_valid_q;
  logic [2*WIDTH-1:0] p_q;
  logic [2*WIDTH-1:0] p_d;
  logic               adv;

  logic [WIDTH-1:0] row_s_in  [WIDTH];
  logic [WIDTH-1:0] row_c_in  [WIDTH];
  logic [WIDTH-1:0] row_s_out [WIDTH];
  logic [WIDTH-1:0] row_c_out [WIDTH];
  logic [WIDTH-1:0] row_p;

  assign adv         = ~out_valid_q | out_ready_i;
  assign in_ready_o  = adv;
  assign out_valid_o = out_valid_q;
  assign p_o         = p_q;

  for (genvar j = 0; j < WIDTH; j++) begin : g_row
    localparam int unsigned K = j / R;
    if (j % R == 0) begin : g_first
      assign row_s_in[j] = pipe_q[K].sum;
      assign row_c_in[j] = pipe_q[K].carry;
    end else begin : g_chain
      assign row_s_in[j] = row_s_out[j-1];
      assign row_c_in[j] = row_c_out[j-1];
    end

    mult_csa_row #(
      .Width(WIDTH)
    ) u_row (
      .sum_i  (row_s_in[j]),
      .carry_i(row_c_in[j]),
      .a_i    (pipe_q[K].a),
      .b_j_i  (pipe_q[K].b[j]),
`ifdef MULT_CSA_SIGNED_EN
      .ctrl_i (row_ctrl(j, WIDTH)),
`endif
      .sum_o  (row_s_out[j]),
      .carry_o(row_c_out[j]),
      .p_o    (row_p[j])
    );
  end

  always_comb begin
    pipe_d[0]       = '0;
    pipe_d[0].valid = in_valid_i;
    pipe_d[0].a     = a_i;
    pipe_d[0].b     = b_i;
    for (int unsigned k = 0; k < NS; k++) begin
      pipe_d[k+1]       = pipe_q[k];
      pipe_d[k+1].sum   = row_s_out[last_row(k, WIDTH, R)];
      pipe_d[k+1].carry = row_c_out[last_row(k, WIDTH, R)];
      for (int unsigned j = 0; j < WIDTH; j++) begin
        if (j / R == k) pipe_d[k+1].plo[j] = row_p[j];
      end
    end
  end

  // Ripple merge of the final carry-save pair into the upper product half.
  // The carry out of the top bit falls beyond the 2*WIDTH-bit result.
  always_comb begin
    logic cy;
    cy  = 1'b0;
    p_d = '0;
    p_d[WIDTH-1:0] = pipe_q[NS].plo;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      p_d[WIDTH+i] = pipe_q[NS].sum[i] ^ pipe_q[NS].carry[i] ^ cy;
      cy = (pipe_q[NS].sum[i] & pipe_q[NS].carry[i]) |
           (cy & (pipe_q[NS].sum[i] ^ pipe_q[NS].carry[i]));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned k = 0; k <= NS; k++) pipe_q[k] <= '0;
      out_valid_q <= 1'b0;
      p_q         <= '0;
    end else if (adv) begin
      for (int unsigned k = 0; k <= NS; k++) pipe_q[k] <= pipe_d[k];
      out_valid_q <= pipe_q[NS].valid;
      p_q         <= p_d;
    end
  end

endmodule

// File: tb/tb_mult_csa_pipe.sv
// Self-checking bench for mult_csa_pipe: reference products come from plain
// integer multiplication; a queue tracks accepted operands in order.
module tb_mult_csa_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned R  = 2;
  localparam int unsigned NS = (W + R - 1) / R;
  localparam int unsigned L  = NS + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] exp_q [$];

  mult_csa_pipe #(
    .WIDTH         (W),
    .ROWS_PER_STAGE(R)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a),
    .b_i        (b),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .p_o        (p)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(logic [W-1:0] x, logic [W-1:0] y);
    logic [2*W-1:0] ex, ey;
`ifdef MULT_CSA_SIGNED_EN
    ex = {{W{x[W-1]}}, x};
    ey = {{W{y[W-1]}}, y};
`else
    ex = {{W{1'b0}}, x};
    ey = {{W{1'b0}}, y};
`endif
    return ex * ey;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++;
    if (p !== '0) begin errors++; $display("FAIL reset_p: got %h want 0", p); end
    step(); step();
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || p !== '0) begin
      errors++; $display("FAIL post_reset_out: got valid=%b p=%h want 0/0", out_valid, p);
    end
  endtask

  task automatic test_single();
    int n;
    logic [2*W-1:0] e;
    out_ready = 1'b1;
    a = {W{1'b1}}; b = {W{1'b1}}; in_valid = 1'b1;
    e = ref_mul(a, b);
    step();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 4 * L) begin step(); n++; end
    checks++;
    if (n != L) begin errors++; $display("FAIL single_latency: got %0d want %0d", n, L); end
    checks++;
    if (p !== e) begin errors++; $display("FAIL single_p: got %h want %h", p, e); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    int got, first, last;
    logic [2*W-1:0] e;
    got = 0; first = -1; last = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 256 + 4 * L; i++) begin
      if (i < 256) begin
        a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready: cycle %0d got %b want 1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid === 1'b1) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (p !== e) begin errors++; $display("FAIL stream_p: item %0d got %h want %h", got, p, e); end
        if (first < 0) first = i;
        last = i;
        got++;
      end
      if (in_valid && in_ready) exp_q.push_back(ref_mul(a, b));
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (got != 256) begin errors++; $display("FAIL stream_count: got %0d want 256", got); end
    checks++;
    if (last - first != 255) begin errors++; $display("FAIL stream_rate: got span %0d want 255", last - first); end
  endtask

  task automatic test_backpressure();
    int n;
    logic [2*W-1:0] e;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = W'(3 + i); b = W'(5); in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_fill_ready: op %0d got %b want 1", i, in_ready); end
      exp_q.push_back(ref_mul(a, b));
      step();
    end
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 4 * L) begin step(); n++; end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || p !== 16'd15) begin
        errors++;
        $display("FAIL bp_stall: cycle %0d got ready=%b valid=%b p=%0d want 0/1/15", c, in_ready, out_valid, p);
      end
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (out_valid !== 1'b1 || p !== e) begin
        errors++; $display("FAIL bp_drain: item %0d got valid=%b p=%0d want 1/%0d", k, out_valid, p, e);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_corner();
    logic [W-1:0] ca [4];
    logic [W-1:0] cb [4];
    logic [2*W-1:0] e;
    int got;
    ca = '{8'd0, 8'd1, 8'd128, 8'd200};
    cb = '{8'd200, 8'd173, 8'd2, 8'd0};
    got = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4 + 4 * L; i++) begin
      if (i < 4) begin a = ca[i]; b = cb[i]; in_valid = 1'b1; end
      else in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (p !== e) begin errors++; $display("FAIL corner_p: item %0d got %h want %h", got, p, e); end
        got++;
      end
      if (in_valid && in_ready) exp_q.push_back(ref_mul(a, b));
      step();
    end
    checks++;
    if (got != 4) begin errors++; $display("FAIL corner_count: got %0d want 4", got); end
  endtask

  task automatic test_reset_mid();
    int n, stale;
    logic [2*W-1:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = W'($urandom_range(1, 255)); b = W'($urandom_range(1, 255)); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 4 * L) begin step(); n++; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || p !== '0) begin
      errors++; $display("FAIL midreset_async: got valid=%b p=%h want 0/0", out_valid, p);
    end
    exp_q.delete();
    step();
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 3 * L; c++) begin
      if (out_valid !== 1'b0) stale++;
      step();
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL midreset_stale: got %0d valid cycles want 0", stale); end
    a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
    e = ref_mul(a, b);
    step();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 4 * L) begin step(); n++; end
    checks++;
    if (n != L || p !== e) begin
      errors++; $display("FAIL midreset_next: got lat=%0d p=%h want %0d/%h", n, p, L, e);
    end
    step();
  endtask

`ifdef MULT_CSA_SIGNED_EN
  task automatic test_signed();
    logic [W-1:0] sa [4];
    logic [W-1:0] sb [4];
    logic [2*W-1:0] se [4];
    int got;
    sa = '{8'h80, 8'hFF, 8'h7F, 8'h80};
    sb = '{8'h80, 8'h7F, 8'h7F, 8'h7F};
    se = '{16'h4000, 16'hFF81, 16'h3F01, 16'hC080};
    got = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4 + 4 * L; i++) begin
      if (i < 4) begin a = sa[i]; b = sb[i]; in_valid = 1'b1; end
      else in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        checks++;
        if (got >= 4 || p !== se[got & 3]) begin
          errors++; $display("FAIL signed_p: item %0d got %h want %h", got, p, se[got & 3]);
        end
        got++;
      end
      step();
    end
    checks++;
    if (got != 4) begin errors++; $display("FAIL signed_count: got %0d want 4", got); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_corner();
    test_reset_mid();
`ifdef MULT_CSA_SIGNED_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
